mem_stage: RTL and testbench

//  Memory-access stage directly downstream of EX. Accepts {wa, we, res, mem_e, mem_n} from EX,

---
 rtl/rv_pkg.sv | 28 ++
 rtl/mem_load_ext.sv | 42 ++++
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared pipeline definitions: memory-op field layout, length codes,
// MEM stage FSM states and the register width.
package rv_pkg;

    localparam int XLEN = 32;

    localparam int ME_EN     = 4;
    localparam int ME_LEN_HI = 3;
    localparam int ME_LEN_LO = 2;
    localparam int ME_WR     = 1;
    localparam int ME_UNS    = 0;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        GNT,
        XFER,
        DONE
    } mem_state_e;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load byte assembly: merges the incoming RAM byte into the partial word
// and sign/zero-extends the result according to the access length.
module mem_load_ext #(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [31:0]     asm_i,
    input  logic [7:0]      din_i,
    input  logic [1:0]      idx_i,
    input  logic [1:0]      len_i,
    input  logic            uns_i,
    output logic [31:0]     asm_o,
    output logic [XLEN-1:0] ext_o
);
    import rv_pkg::*;

    logic sgn;

    always_comb begin
        asm_o = asm_i;
        asm_o[{idx_i, 3'b000} +: 8] = din_i;
        sgn   = 1'b0;
        ext_o = '0;
        case (len_i)
            LEN_B: begin
                sgn = ~uns_i & asm_o[7];
                ext_o = {XLEN{sgn}};
                ext_o[7:0] = asm_o[7:0];
            end
            LEN_H: begin
                sgn = ~uns_i & asm_o[15];
                ext_o = {XLEN{sgn}};
                ext_o[15:0] = asm_o[15:0];
            end
            default: begin
                sgn = ~uns_i & asm_o[31];
                ext_o = {XLEN{sgn}};
                ext_o[31:0] = asm_o;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over a shared 8-bit RAM port.
// Define MEM_STAGE_FWD_EN to drive the fwd_* bypass to ID.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = rv_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wa,
    input  logic              ex_we,
    input  logic [XLEN-1:0]   ex_res,
    input  logic [4:0]        ex_mem_e,
    input  logic [XLEN-1:0]   ex_mem_n,
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stall_req,
    output logic [4:0]        wb_wa,
    output logic              wb_we,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        fwd_wa,
    output logic              fwd_we,
    output logic [XLEN-1:0]   fwd_data
);
    import rv_pkg::*;

    mem_state_e        state_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   data_q;
    logic [4:0]        wa_q;
    logic              we_q;
    logic [1:0]        len_q;
    logic              wr_q;
    logic              uns_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_d;
    logic              ram_req_q;
    logic [4:0]        wb_wa_q;
    logic              wb_we_q;
    logic [XLEN-1:0]   wb_data_q;

    logic              en_ok;
    logic [2:0]        nbytes;
    logic [2:0]        last_cnt;
    logic              addr_ph;
    logic [1:0]        cap_idx;
    logic [XLEN-1:0]   ext_data;

    // len=2 is not a legal size; such ops fall through as plain ALU results
    assign en_ok = ex_mem_e[ME_EN]
                 && (ex_mem_e[ME_LEN_HI:ME_LEN_LO] != 2'd2);

    assign nbytes   = len_bytes(len_q);
    assign last_cnt = wr_q ? nbytes - 3'd1 : nbytes;
    assign addr_ph  = (state_q == XFER) && (cnt_q < nbytes);
    assign cap_idx  = 2'(cnt_q - 3'd1);

    assign ram_req  = ram_req_q;
    assign ram_a    = addr_ph ? addr_q + ADDR_W'(cnt_q) : '0;
    assign ram_wr   = addr_ph & wr_q;
    assign ram_dout = (addr_ph & wr_q)
                    ? data_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

    assign stall_req = (state_q == IDLE) ? en_ok
                     : (state_q != DONE);

    assign wb_wa   = wb_wa_q;
    assign wb_we   = wb_we_q;
    assign wb_data = wb_data_q;

`ifdef MEM_STAGE_FWD_EN
    assign fwd_wa   = wb_wa_q;
    assign fwd_we   = wb_we_q;
    assign fwd_data = wb_data_q;
`else
    assign fwd_wa   = '0;
    assign fwd_we   = 1'b0;
    assign fwd_data = '0;
`endif

    mem_load_ext #(
        .XLEN(XLEN)
    ) u_ext (
        .asm_i(asm_q),
        .din_i(ram_din),
        .idx_i(cap_idx),
        .len_i(len_q),
        .uns_i(uns_q),
        .asm_o(asm_d),
        .ext_o(ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wa_q      <= '0;
            we_q      <= 1'b0;
            len_q     <= '0;
            wr_q      <= 1'b0;
            uns_q     <= 1'b0;
            asm_q     <= '0;
            ram_req_q <= 1'b0;
            wb_wa_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_data_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_ok) begin
                        state_q   <= GNT;
                        ram_req_q <= 1'b1;
                        addr_q    <= ex_res[ADDR_W-1:0];
                        data_q    <= ex_mem_n;
                        wa_q      <= ex_wa;
                        we_q      <= ex_we;
                        len_q     <= ex_mem_e[ME_LEN_HI:ME_LEN_LO];
                        wr_q      <= ex_mem_e[ME_WR];
                        uns_q     <= ex_mem_e[ME_UNS];
                        asm_q     <= '0;
                        cnt_q     <= '0;
                        wb_we_q   <= 1'b0;
                    end else begin
                        wb_wa_q   <= ex_wa;
                        wb_we_q   <= ex_we;
                        wb_data_q <= ex_res;
                    end
                end
                GNT: begin
                    if (ram_gnt) begin
                        state_q <= XFER;
                        cnt_q   <= '0;
                    end
                end
                XFER: begin
                    // load data lags its address by one cycle
                    if (!wr_q && cnt_q != 3'd0) begin
                        asm_q <= asm_d;
                    end
                    if (cnt_q == last_cnt) begin
                        state_q   <= DONE;
                        ram_req_q <= 1'b0;
                        wb_wa_q   <= wa_q;
                        wb_we_q   <= we_q & ~wr_q;
                        wb_data_q <= wr_q ? '0 : ext_data;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    wb_we_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_gnt_held: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == XFER) |-> ram_gnt
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized ops
// against an instruction-level reference model, and a mid-transfer reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wa;
    logic        ex_we;
    logic [31:0] ex_res;
    logic [4:0]  ex_mem_e;
    logic [31:0] ex_mem_n;
    logic        ram_req;
    logic        ram_gnt;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;
    logic        stall_req;
    logic [4:0]  wb_wa;
    logic        wb_we;
    logic [31:0] wb_data;
    logic [4:0]  fwd_wa;
    logic        fwd_we;
    logic [31:0] fwd_data;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_wa(ex_wa), .ex_we(ex_we), .ex_res(ex_res),
        .ex_mem_e(ex_mem_e), .ex_mem_n(ex_mem_n),
        .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_a(ram_a),
        .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .stall_req(stall_req),
        .wb_wa(wb_wa), .wb_we(wb_we), .wb_data(wb_data),
        .fwd_wa(fwd_wa), .fwd_we(fwd_we), .fwd_data(fwd_data)
    );

    // arbiter: grant after gnt_delay cycles of request, held while requested
    int gnt_delay = 0;
    int wait_cnt = 0;
    always @(posedge clk) wait_cnt <= ram_req ? wait_cnt + 1 : 0;
    assign ram_gnt = ram_req && (wait_cnt >= gnt_delay);

    function automatic logic [7:0] pre(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    logic       tb_init = 1'b0;
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pre(i);
        end else if (ram_req && ram_gnt && ram_wr) begin
            mem[ram_a[11:0]] <= ram_dout;
        end
        ram_din <= (ram_req && ram_gnt && !ram_wr) ? mem[ram_a[11:0]] : 8'h00;
    end

    logic [7:0] ref_mem [0:4095];

    int pass_n = 0;
    int total_n = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total_n++;
        if (act === req) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    // instruction-level model: result, latency, memory effect
    task automatic ref_exec(input logic we, input logic [31:0] res,
                            input logic [4:0] me, input logic [31:0] mn,
                            input int gd, output logic xwe,
                            output logic [31:0] xdata, output int xlat);
        int n;
        logic [31:0] a;
        logic [63:0] v;
        xwe = we;
        xdata = res;
        xlat = 1;
        if (me[4] && me[3:2] != 2'd2) begin
            n = int'(me[3:2]) + 1;
            v = 64'd0;
            for (int i = 0; i < n; i++) begin
                a = res + 32'(i);
                if (me[1]) ref_mem[a[11:0]] = 8'(mn >> (8 * i));
                else v = v | (64'(ref_mem[a[11:0]]) << (8 * i));
            end
            if (me[1]) begin
                xwe = 1'b0;
                xdata = 32'd0;
                xlat = n + 2 + gd;
            end else begin
                if (!me[0] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                xdata = v[31:0];
                xlat = n + 3 + gd;
            end
        end
    endtask

    task automatic bubble();
        ex_wa = '0; ex_we = 1'b0; ex_res = '0; ex_mem_e = '0; ex_mem_n = '0;
    endtask

    task automatic run_op(input logic [4:0] wa, input logic we,
                          input logic [31:0] res, input logic [4:0] me,
                          input logic [31:0] mn, input int gd,
                          output logic owe, output logic [4:0] owa,
                          output logic [31:0] odata, output int lat);
        logic mop;
        logic ok;
        gnt_delay = gd;
        ex_wa = wa; ex_we = we; ex_res = res; ex_mem_e = me; ex_mem_n = mn;
        mop = me[4] && (me[3:2] != 2'd2);
        #1;
        ok = (stall_req === mop);
        lat = 0;
        if (!mop) begin
            @(posedge clk); #1;
            lat = 1;
        end else begin
            while (1) begin
                @(posedge clk); #1;
                lat++;
                if (stall_req === 1'b0) break;
                if (wb_we !== 1'b0 || ram_req !== 1'b1) ok = 1'b0;
                if (lat > 60) break;
            end
            chk("timeout", 64'(lat > 60), 64'd0);
            chk("req_drop", 64'(ram_req), 64'd0);
        end
        owe = wb_we;
        owa = wb_wa;
        odata = wb_data;
`ifdef MEM_STAGE_FWD_EN
        chk("fwd", {fwd_we, fwd_wa, fwd_data}, {wb_we, wb_wa, wb_data});
`else
        chk("fwd", {fwd_we, fwd_wa, fwd_data}, 64'd0);
`endif
        chk("stall", 64'(ok), 64'd1);
        bubble();
        @(posedge clk); #1;
        chk("pulse", 64'(wb_we), 64'd0);
    endtask

    typedef struct {
        logic [4:0]  wa;
        logic        we;
        logic [31:0] res;
        logic [4:0]  me;
        logic [31:0] mn;
        int          gd;
        logic        xwe;
        logic [31:0] xdata;
        int          xlat;
    } vec_t;

    initial begin
        vec_t tbl [17];
        logic owe, rwe;
        logic [4:0] owa;
        logic [31:0] od, rd;
        int lat, rlat, diffs;
        logic ok;

        tbl[0]  = '{5'd5,  1'b1, 32'h1234,     5'b00000, 32'h0,        0, 1'b1, 32'h1234,     1};
        tbl[1]  = '{5'd4,  1'b0, 32'h100,      5'b10010, 32'h80,       0, 1'b0, 32'h0,        3};
        tbl[2]  = '{5'd6,  1'b1, 32'h100,      5'b10000, 32'h0,        0, 1'b1, 32'hFFFFFF80, 4};
        tbl[3]  = '{5'd6,  1'b1, 32'h100,      5'b10001, 32'h0,        0, 1'b1, 32'h00000080, 4};
        tbl[4]  = '{5'd2,  1'b1, 32'h100,      5'b11110, 32'hA1B2C3D4, 0, 1'b0, 32'h0,        6};
        tbl[5]  = '{5'd7,  1'b1, 32'h100,      5'b11100, 32'h0,        3, 1'b1, 32'hA1B2C3D4, 10};
        tbl[6]  = '{5'd8,  1'b1, 32'h102,      5'b10100, 32'h0,        1, 1'b1, 32'hFFFFA1B2, 6};
        tbl[7]  = '{5'd8,  1'b1, 32'h100,      5'b10101, 32'h0,        0, 1'b1, 32'h0000C3D4, 5};
        tbl[8]  = '{5'd10, 1'b1, 32'h103,      5'b10000, 32'h0,        2, 1'b1, 32'hFFFFFFA1, 6};
        tbl[9]  = '{5'd9,  1'b1, 32'hDEAD,     5'b11000, 32'h0,        0, 1'b1, 32'hDEAD,     1};
        tbl[10] = '{5'd1,  1'b0, 32'hFFFFFFFE, 5'b11110, 32'h11223344, 0, 1'b0, 32'h0,        6};
        tbl[11] = '{5'd11, 1'b1, 32'hFFFFFFFE, 5'b11100, 32'h0,        0, 1'b1, 32'h11223344, 7};
        tbl[12] = '{5'd0,  1'b1, 32'h55,       5'b00000, 32'h0,        0, 1'b1, 32'h55,       1};
        tbl[13] = '{5'd12, 1'b0, 32'h100,      5'b11100, 32'h0,        0, 1'b0, 32'h0,        7};
        tbl[14] = '{5'd13, 1'b1, 32'h100,      5'b10110, 32'h0000BEEF, 0, 1'b0, 32'h0,        4};
        tbl[15] = '{5'd14, 1'b1, 32'h100,      5'b11100, 32'h0,        0, 1'b1, 32'hA1B2BEEF, 7};
        tbl[16] = '{5'd15, 1'b1, 32'hFFFFFFFF, 5'b10101, 32'h0,        0, 1'b1, 32'h00002233, 5};

        for (int i = 0; i < 4096; i++) ref_mem[i] = pre(i);

        rst = 1'b1;
        tb_init = 1'b1;
        bubble();
        repeat (2) @(posedge clk);
        #1;
        tb_init = 1'b0;
        chk("rst_ram", {ram_req, ram_wr, ram_dout, stall_req, ram_a}, 64'd0);
        chk("rst_wb", {wb_we, wb_wa, wb_data}, 64'd0);
        chk("rst_fwd", {fwd_we, fwd_wa, fwd_data}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            run_op(tbl[i].wa, tbl[i].we, tbl[i].res, tbl[i].me, tbl[i].mn,
                   tbl[i].gd, owe, owa, od, lat);
            ref_exec(tbl[i].we, tbl[i].res, tbl[i].me, tbl[i].mn, tbl[i].gd,
                     rwe, rd, rlat);
            chk($sformatf("v%0d_we", i), 64'(owe), 64'(tbl[i].xwe));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tbl[i].xlat));
            if (tbl[i].xwe) begin
                chk($sformatf("v%0d_wa", i), 64'(owa), 64'(tbl[i].wa));
                chk($sformatf("v%0d_data", i), 64'(od), 64'(tbl[i].xdata));
            end
        end

        chk("mem_100", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]},
            64'hA1B2BEEF);
        chk("mem_wrap", {mem[12'h001], mem[12'h000], mem[12'hFFF], mem[12'hFFE]},
            64'h11223344);

        for (int k = 0; k < 80; k++) begin
            logic [4:0] wa, me;
            logic we;
            logic [31:0] res, mn;
            int gd, kind;
            logic [1:0] ln;
            kind = int'($urandom_range(0, 9));
            wa = 5'($urandom);
            we = 1'($urandom);
            mn = $urandom;
            gd = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                res = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else
                res = 32'h300 + 32'($urandom_range(0, 127));
            case ($urandom_range(0, 2))
                0: ln = 2'd0;
                1: ln = 2'd1;
                default: ln = 2'd3;
            endcase
            if (kind < 3) me = {1'b0, 4'($urandom)};
            else if (kind == 3) me = {1'b1, 2'd2, 2'($urandom)};
            else me = {1'b1, ln, 2'($urandom)};
            run_op(wa, we, res, me, mn, gd, owe, owa, od, lat);
            ref_exec(we, res, me, mn, gd, rwe, rd, rlat);
            chk($sformatf("r%0d_we", k), 64'(owe), 64'(rwe));
            chk($sformatf("r%0d_lat", k), 64'(lat), 64'(rlat));
            if (rwe) begin
                chk($sformatf("r%0d_wa", k), 64'(owa), 64'(wa));
                chk($sformatf("r%0d_data", k), 64'(od), 64'(rd));
            end
        end

        diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 64'(diffs), 64'd0);

        // reset while the third byte of a word store is on the bus
        gnt_delay = 0;
        ex_wa = 5'd3; ex_we = 1'b0; ex_res = 32'h200;
        ex_mem_e = 5'b11110; ex_mem_n = 32'hCAFEBABE;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("xfer_b2", {ram_wr, ram_a}, {1'b1, 32'h202});
        rst = 1'b1;
        bubble();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_abort", {ram_req, stall_req, wb_we}, 64'd0);
        ok = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (wb_we !== 1'b0 || ram_req !== 1'b0) ok = 1'b0;
        end
        chk("rst_quiet", 64'(ok), 64'd1);
        chk("rst_partial", {mem[12'h203], mem[12'h201], mem[12'h200]},
            {40'd0, ref_mem[12'h203], 16'hBABE});

        run_op(5'd4, 1'b1, 32'h200, 5'b10000, 32'h0, 0, owe, owa, od, lat);
        chk("post_rst_lb", {owe, owa, od}, {1'b1, 5'd4, 32'hFFFFFFBE});
        chk("post_rst_lat", 64'(lat), 64'd4);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
